// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-ported data memory between the pipeline MEM stage (CPU)
// and the host/DMA loader. The CPU wins by default. A saturating wait counter
// force-grants the DMA port after STARVE_LIMIT denied cycles so DMA always
// makes progress. Load data is captured one edge after the grant and returned
// with a one-cycle rvalid pulse to whichever requester owned the access.

module dmem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU (MEM stage) requester
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]      cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [WIDTH-1:0]      cpu_rdata,
    // DMA / host loader requester
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [WIDTH-1:0]      dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [WIDTH-1:0]      dma_rdata,
    // Data memory port
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wd,
    input  logic [WIDTH-1:0]      mem_rd
);

    // Starvation threshold expressed in the counter's own width.
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    // Read-return tracking: which requester (if any) gets data this cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RD_CPU = 2'b01,
        ST_RD_DMA = 2'b10
    } rd_state_e;

    rd_state_e             state_r;
    rd_state_e             state_nxt_s;
    logic [3:0]            wait_cnt_r;
    logic [3:0]            wait_cnt_nxt_s;
    logic                  force_s;
    logic                  cpu_gnt_s;
    logic                  dma_gnt_s;
    logic                  cpu_stall_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [WIDTH-1:0]      mem_wd_s;
    logic                  cpu_rvalid_s;
    logic                  dma_rvalid_s;
    logic [WIDTH-1:0]      cpu_rdata_r;
    logic [WIDTH-1:0]      dma_rdata_r;

    // Grant decision: CPU priority unless the DMA has waited STARVE_LIMIT cycles.
    always_comb begin
        force_s     = 1'b0;
        dma_gnt_s   = 1'b0;
        cpu_gnt_s   = 1'b0;
        cpu_stall_s = 1'b0;
        if (dma_req && (wait_cnt_r == LIMIT_C)) begin
            force_s = 1'b1;
        end else begin
            force_s = 1'b0;
        end
        dma_gnt_s   = dma_req & (~cpu_req | force_s);
        cpu_gnt_s   = cpu_req & ~dma_gnt_s;
        cpu_stall_s = cpu_req & ~cpu_gnt_s;
    end

    // Memory port mux: the granted requester drives the memory; idle drives zeros.
    // Write enable is gated by reset so nothing is written while rst is low.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = {ADDR_WIDTH{1'b0}};
        mem_wd_s   = {WIDTH{1'b0}};
        case ({cpu_gnt_s, dma_gnt_s})
            2'b10: begin
                mem_we_s   = cpu_we & rst;
                mem_addr_s = cpu_addr;
                mem_wd_s   = cpu_wdata;
            end
            2'b01: begin
                mem_we_s   = dma_we & rst;
                mem_addr_s = dma_addr;
                mem_wd_s   = dma_wdata;
            end
            default: begin
                mem_we_s   = 1'b0;
                mem_addr_s = {ADDR_WIDTH{1'b0}};
                mem_wd_s   = {WIDTH{1'b0}};
            end
        endcase
    end

    // Wait counter next value: restart on grant or withdrawal, count denied cycles.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (dma_gnt_s || !dma_req) begin
            wait_cnt_nxt_s = 4'd0;
        end else if (wait_cnt_r >= LIMIT_C) begin
            wait_cnt_nxt_s = LIMIT_C;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 4'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Read-return FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read-return FSM next state: a granted load schedules a return next cycle.
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (cpu_gnt_s && !cpu_we) begin
            state_nxt_s = ST_RD_CPU;
        end else if (dma_gnt_s && !dma_we) begin
            state_nxt_s = ST_RD_DMA;
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // Read-return FSM outputs: rvalid is decoded straight from the state register.
    always_comb begin
        cpu_rvalid_s = 1'b0;
        dma_rvalid_s = 1'b0;
        case (state_r)
            ST_RD_CPU: begin
                cpu_rvalid_s = 1'b1;
                dma_rvalid_s = 1'b0;
            end
            ST_RD_DMA: begin
                cpu_rvalid_s = 1'b0;
                dma_rvalid_s = 1'b1;
            end
            default: begin
                cpu_rvalid_s = 1'b0;
                dma_rvalid_s = 1'b0;
            end
        endcase
    end

    // CPU load data capture: sample memory on the edge that enters RD_CPU, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata_r <= {WIDTH{1'b0}};
        end else if (state_nxt_s == ST_RD_CPU) begin
            cpu_rdata_r <= mem_rd;
        end else begin
            cpu_rdata_r <= cpu_rdata_r;
        end
    end

    // DMA read data capture: sample memory on the edge that enters RD_DMA, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rdata_r <= {WIDTH{1'b0}};
        end else if (state_nxt_s == ST_RD_DMA) begin
            dma_rdata_r <= mem_rd;
        end else begin
            dma_rdata_r <= dma_rdata_r;
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign dma_gnt    = dma_gnt_s;
    assign cpu_stall  = cpu_stall_s;
    assign mem_we     = mem_we_s;
    assign mem_addr   = mem_addr_s;
    assign mem_wd     = mem_wd_s;
    assign cpu_rvalid = cpu_rvalid_s;
    assign dma_rvalid = dma_rvalid_s;
    assign cpu_rdata  = cpu_rdata_r;
    assign dma_rdata  = dma_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vectors, expected grants and read
// returns queued at stimulus time and checked by a negedge monitor.

module tb_dmem_arbiter;

    typedef struct packed {
        logic        cg;
        logic        dg;
        logic        st;
        logic        we;
        logic [31:0] addr;
    } gnt_exp_t;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    logic [31:0] mem_model [0:63];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    gnt_exp_t gq[$];
    rd_exp_t  cq[$];
    rd_exp_t  dq[$];
    gnt_exp_t mon_g;
    rd_exp_t  mon_r;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Behavioural data memory: combinational read, write on the rising edge.
    assign mem_rd = mem_model[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr[7:2]] <= mem_wd;
    end

    // Cycle counter used to time read returns.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compares grants every driven cycle and read returns when due.
    always @(negedge clk) begin
        if (gq.size() > 0) begin
            mon_g = gq.pop_front();
            checks++;
            if ({cpu_gnt, dma_gnt, cpu_stall, mem_we, mem_addr} !== mon_g) begin
                errors++;
                $display("FAIL grant cyc %0d: got cg=%b dg=%b st=%b we=%b addr=%h expected cg=%b dg=%b st=%b we=%b addr=%h",
                         cyc, cpu_gnt, dma_gnt, cpu_stall, mem_we, mem_addr,
                         mon_g.cg, mon_g.dg, mon_g.st, mon_g.we, mon_g.addr);
            end
        end
        if (cq.size() > 0 && cq[0].due == 32'(cyc)) begin
            mon_r = cq.pop_front();
            checks++;
            if (cpu_rvalid !== 1'b1 || cpu_rdata !== mon_r.data) begin
                errors++;
                $display("FAIL cpu_read cyc %0d: got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                         cyc, cpu_rvalid, cpu_rdata, mon_r.data);
            end
        end else if (cpu_rvalid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL cpu_rvalid cyc %0d: got %b expected 0", cyc, cpu_rvalid);
        end
        if (dq.size() > 0 && dq[0].due == 32'(cyc)) begin
            mon_r = dq.pop_front();
            checks++;
            if (dma_rvalid !== 1'b1 || dma_rdata !== mon_r.data) begin
                errors++;
                $display("FAIL dma_read cyc %0d: got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                         cyc, dma_rvalid, dma_rdata, mon_r.data);
            end
        end else if (dma_rvalid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL dma_rvalid cyc %0d: got %b expected 0", cyc, dma_rvalid);
        end
    end

    // Drive one cycle of inputs shortly after the rising edge and queue the expected grant.
    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                         input gnt_exp_t e);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        gq.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, {1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    endtask

    task automatic push_cpu(input logic [31:0] d);
        cq.push_back({32'(cyc + 1), d});
    endtask

    task automatic push_dma(input logic [31:0] d);
        dq.push_back({32'(cyc + 1), d});
    endtask

    initial begin
        logic        cr, cw, dr, dw, eg_c, eg_d;
        logic [31:0] ca, cd, da, dd;

        for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
        mem_model[8] = 32'h12345678;
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;

        // Reset held with random inputs: grants follow requests, nothing written or returned.
        for (int i = 0; i < 4; i++) begin
            cr = 1'($urandom_range(0, 1)); cw = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1)); dw = 1'($urandom_range(0, 1));
            ca = {$urandom} & 32'h0000_00FC; cd = $urandom;
            da = {$urandom} & 32'h0000_00FC; dd = $urandom;
            eg_d = dr & ~cr;
            eg_c = cr & ~eg_d;
            drive(cr, cw, ca, cd, dr, dw, da, dd,
                  {eg_c, eg_d, 1'b0, 1'b0, eg_c ? ca : (eg_d ? da : 32'h0)});
            #3;
            check("reset_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
            check("reset_dma_rvalid", {31'h0, dma_rvalid}, 32'h0);
            check("reset_cpu_rdata", cpu_rdata, 32'h0);
            check("reset_dma_rdata", dma_rdata, 32'h0);
        end

        // Release reset on an idle cycle.
        idle();
        rst = 1'b1;

        // CPU only: store then load 0x10.
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, {1'b1, 1'b0, 1'b0, 1'b1, 32'h10});
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, {1'b1, 1'b0, 1'b0, 1'b0, 32'h10});
        push_cpu(32'hDEADBEEF);
        idle();

        // Contention: CPU loads 0x10 continuously, DMA reads 0x20 until granted on cycle 4.
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, {1'b1, 1'b0, 1'b0, 1'b0, 32'h10});
                push_cpu(32'hDEADBEEF);
            end else if (k == 4) begin
                drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, {1'b0, 1'b1, 1'b1, 1'b0, 32'h20});
                push_dma(32'h12345678);
            end else begin
                drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, {1'b1, 1'b0, 1'b0, 1'b0, 32'h10});
                push_cpu(32'hDEADBEEF);
            end
        end
        idle();

        // DMA only: 8 writes then 8 back-to-back reads of 0x00..0x1C.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i),
                  {1'b0, 1'b1, 1'b0, 1'b1, 32'(i * 4)});
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'(i * 4), 32'h0,
                  {1'b0, 1'b1, 1'b0, 1'b0, 32'(i * 4)});
            push_dma(32'hC0DE0000 | 32'(i));
        end
        idle();

        // Withdrawal: DMA contends 2 cycles, drops 1, re-requests; granted 4 cycles later.
        for (int k = 0; k < 9; k++) begin
            if (k == 7) begin
                drive(1'b1, 1'b1, 32'h30, 32'hFACEF00D, 1'b1, 1'b0, 32'h20, 32'h0, {1'b0, 1'b1, 1'b1, 1'b0, 32'h20});
                push_dma(32'h12345678);
            end else begin
                dr = (k != 2 && k < 7) ? 1'b1 : 1'b0;
                drive(1'b1, 1'b1, 32'h30, 32'hFACEF00D, dr, 1'b0, 32'h20, 32'h0, {1'b1, 1'b0, 1'b0, 1'b1, 32'h30});
            end
        end
        idle();

        // Reset mid-read: a granted CPU load must not return data.
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, {1'b1, 1'b0, 1'b0, 1'b0, 32'h20});
        #2;
        rst = 1'b0;
        idle();
        #2;
        check("midread_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
        check("midread_cpu_rdata", cpu_rdata, 32'h0);
        rst = 1'b1;
        idle();
        idle();
        @(posedge clk);
        #1;

        check("pending_cpu_reads", 32'(cq.size()), 32'h0);
        check("pending_dma_reads", 32'(dq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
